// File: rtl/chacha_regmap_pkg.sv
// Register map of the chacha slave and the state encoding of its bus master.
package chacha_regmap_pkg;

  localparam logic [7:0] ADDR_CONTROL     = 8'h0a;
  localparam logic [7:0] ADDR_STATUS      = 8'h0b;
  localparam logic [7:0] ADDR_KEYLEN      = 8'h0c;
  localparam logic [7:0] ADDR_ROUNDS      = 8'h0d;
  localparam logic [7:0] ADDR_KEY_BASE    = 8'h30;
  localparam logic [7:0] ADDR_NONCE_BASE  = 8'h38;
  localparam logic [7:0] ADDR_INPUT_BASE  = 8'h50;
  localparam logic [7:0] ADDR_OUTPUT_BASE = 8'h70;

  localparam int STATUS_READY_BIT = 0;
  localparam int CTRL_INIT_BIT    = 0;
  localparam logic [31:0] CTRL_INIT_WORD = 32'h1 << CTRL_INIT_BIT;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_NONCE,
    ST_WR_ROUNDS,
    ST_WR_KEYLEN,
    ST_WR_DATA,
    ST_CTRL_SET,
    ST_HOLD,
    ST_CTRL_CLR,
    ST_GAP,
    ST_POLL,
    ST_RD_OUT,
    ST_DONE
  } cbm_state_e;

endpackage

// File: rtl/chacha_bus_master_if.sv
// Register-bus signals between the master and the chacha slave.
interface chacha_bus_master_if;
  logic        cs;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output cs, output we, output addr, output write_data, input read_data);
  modport slave  (input cs, input we, input addr, input write_data, output read_data);
endinterface

// File: rtl/chacha_bus_port.sv
// One-shot bus executor: writes complete in the issue cycle, reads complete
// READ_LAT edges after the slave sees the issue cycle.
module chacha_bus_port #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  chacha_bus_master_if.master bus
);

  localparam int LW = $clog2(READ_LAT + 1);

  logic [LW-1:0] lat_cnt;
  logic          issue;

  // req may stay high while a read is in flight; it only issues once idle
  assign issue          = req && (lat_cnt == '0);
  assign bus.cs         = issue;
  assign bus.we         = issue && we;
  assign bus.addr       = issue ? addr : 8'h00;
  assign bus.write_data = (issue && we) ? wdata : 32'h0;

  assign done  = (issue && we) || (lat_cnt == LW'(1));
  assign rdata = bus.read_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
    end else if (issue && !we) begin
      lat_cnt <= LW'(READ_LAT);
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LW'(1);
    end
  end

endmodule

// File: rtl/chacha_bus_master.sv
// Programs one job into the chacha slave, waits for ready, reads the block back.
//   state     | meaning
//   IDLE      | waiting for a job
//   WR_KEY    | key words to 0x30..0x37
//   WR_NONCE  | nonce words to 0x38..0x3a
//   WR_ROUNDS | rounds to 0x0d
//   WR_KEYLEN | keylen to 0x0c
//   WR_DATA   | input block to 0x50..0x5f
//   CTRL_SET  | init bit set
//   HOLD      | INIT_HOLD idle cycles
//   CTRL_CLR  | init bit cleared
//   GAP       | POLL_GAP idle cycles
//   POLL      | status reads until ready or TIMEOUT
//   RD_OUT    | output block from 0x70..0x7f
//   DONE      | result presented until accepted
module chacha_bus_master
  import chacha_regmap_pkg::*;
#(
  parameter int READ_LAT  = 1,
  parameter int INIT_HOLD = 2,
  parameter int POLL_GAP  = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_key,
  input  logic [95:0]  job_nonce,
  input  logic [4:0]   job_rounds,
  input  logic         job_keylen,
  input  logic [511:0] job_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [511:0] res_data,
  output logic         res_error,
  chacha_bus_master_if.master bus
);

  localparam int PW = $clog2(TIMEOUT + 1);

  cbm_state_e     state, state_nx;
  logic [4:0]     word_cnt;
  logic [15:0]    dly_cnt;
  logic [PW-1:0]  poll_cnt;
  logic [255:0]   key_q;
  logic [95:0]    nonce_q;
  logic [4:0]     rounds_q;
  logic           keylen_q;
  logic [511:0]   data_q;

  logic           port_req, port_we, port_done;
  logic [7:0]     port_addr;
  logic [31:0]    port_wdata, port_rdata;

  chacha_bus_port #(.READ_LAT(READ_LAT)) u_port (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (port_req),
    .we      (port_we),
    .addr    (port_addr),
    .wdata   (port_wdata),
    .done    (port_done),
    .rdata   (port_rdata),
    .bus     (bus)
  );

  assign job_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);

  always_comb begin
    state_nx   = state;
    port_req   = 1'b0;
    port_we    = 1'b0;
    port_addr  = 8'h00;
    port_wdata = 32'h0;
    case (state)
      ST_IDLE: if (job_valid) state_nx = ST_WR_KEY;
      ST_WR_KEY: begin
        port_req   = 1'b1;
        port_we    = 1'b1;
        port_addr  = ADDR_KEY_BASE + {5'd0, word_cnt[2:0]};
        port_wdata = key_q[{~word_cnt[2:0], 5'd0} +: 32];
        if (port_done && word_cnt == 5'd7) state_nx = ST_WR_NONCE;
      end
      ST_WR_NONCE: begin
        port_req   = 1'b1;
        port_we    = 1'b1;
        port_addr  = ADDR_NONCE_BASE + {6'd0, word_cnt[1:0]};
        case (word_cnt[1:0])
          2'd0:    port_wdata = nonce_q[95:64];
          2'd1:    port_wdata = nonce_q[63:32];
          default: port_wdata = nonce_q[31:0];
        endcase
        if (port_done && word_cnt == 5'd2) state_nx = ST_WR_ROUNDS;
      end
      ST_WR_ROUNDS: begin
        port_req   = 1'b1;
        port_we    = 1'b1;
        port_addr  = ADDR_ROUNDS;
        port_wdata = {27'd0, rounds_q};
        if (port_done) state_nx = ST_WR_KEYLEN;
      end
      ST_WR_KEYLEN: begin
        port_req   = 1'b1;
        port_we    = 1'b1;
        port_addr  = ADDR_KEYLEN;
        port_wdata = {31'd0, keylen_q};
        if (port_done) state_nx = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        port_req   = 1'b1;
        port_we    = 1'b1;
        port_addr  = ADDR_INPUT_BASE + {4'd0, word_cnt[3:0]};
        port_wdata = data_q[{~word_cnt[3:0], 5'd0} +: 32];
        if (port_done && word_cnt == 5'd15) state_nx = ST_CTRL_SET;
      end
      ST_CTRL_SET: begin
        port_req   = 1'b1;
        port_we    = 1'b1;
        port_addr  = ADDR_CONTROL;
        port_wdata = CTRL_INIT_WORD;
        if (port_done) state_nx = ST_HOLD;
      end
      ST_HOLD: if (dly_cnt == 16'(INIT_HOLD - 1)) state_nx = ST_CTRL_CLR;
      ST_CTRL_CLR: begin
        port_req  = 1'b1;
        port_we   = 1'b1;
        port_addr = ADDR_CONTROL;
        if (port_done) state_nx = ST_GAP;
      end
      ST_GAP: if (dly_cnt == 16'(POLL_GAP - 1)) state_nx = ST_POLL;
      ST_POLL: begin
        port_req  = 1'b1;
        port_addr = ADDR_STATUS;
        if (port_done) begin
          if (port_rdata[STATUS_READY_BIT])         state_nx = ST_RD_OUT;
          else if (poll_cnt == PW'(TIMEOUT - 1))    state_nx = ST_DONE;
        end
      end
      ST_RD_OUT: begin
        port_req  = 1'b1;
        port_addr = ADDR_OUTPUT_BASE + {4'd0, word_cnt[3:0]};
        if (port_done && word_cnt == 5'd15) state_nx = ST_DONE;
      end
      ST_DONE: if (res_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      dly_cnt   <= '0;
      poll_cnt  <= '0;
      key_q     <= '0;
      nonce_q   <= '0;
      rounds_q  <= '0;
      keylen_q  <= 1'b0;
      data_q    <= '0;
      res_data  <= '0;
      res_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        word_cnt <= '0;
        dly_cnt  <= '0;
      end else begin
        if (port_done) word_cnt <= word_cnt + 5'd1;
        if (state == ST_HOLD || state == ST_GAP) dly_cnt <= dly_cnt + 16'd1;
      end
      if (state == ST_IDLE && job_valid) begin
        key_q     <= job_key;
        nonce_q   <= job_nonce;
        rounds_q  <= job_rounds;
        keylen_q  <= job_keylen;
        data_q    <= job_data;
        poll_cnt  <= '0;
        res_data  <= '0;
        res_error <= 1'b0;
      end
      if (state == ST_POLL && port_done) begin
        poll_cnt <= poll_cnt + PW'(1);
        // timed-out result leaves res_data at the zero set on accept
        if (state_nx == ST_DONE) res_error <= 1'b1;
      end
      if (state == ST_RD_OUT && port_done) res_data[{~word_cnt[3:0], 5'd0} +: 32] <= port_rdata;
    end
  end

endmodule

// File: tb/tb_chacha_bus_master.sv
// Directed bench: behavioural chacha slave with bus logging around one master.
module tb_chacha_bus_master;
  import chacha_regmap_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [255:0] job_key = '0;
  logic [95:0]  job_nonce = '0;
  logic [4:0]   job_rounds = '0;
  logic         job_keylen = 1'b0;
  logic [511:0] job_data = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [511:0] res_data;
  logic         res_error;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chacha_bus_master_if bus ();

  chacha_bus_master #(.READ_LAT(1), .INIT_HOLD(2), .POLL_GAP(2), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_key    (job_key),
    .job_nonce  (job_nonce),
    .job_rounds (job_rounds),
    .job_keylen (job_keylen),
    .job_data   (job_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_error  (res_error),
    .bus        (bus)
  );

  // slave model and bus log
  int          cyc = 0;
  int          stat_reads = 0;
  int          stat_base = 0;
  int          miss_target = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  rd_addr[$];
  int          rd_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cs && bus.we) begin
      wr_addr.push_back(bus.addr);
      wr_data.push_back(bus.write_data);
      wr_cyc.push_back(cyc);
    end
    if (bus.cs && !bus.we) begin
      rd_addr.push_back(bus.addr);
      rd_cyc.push_back(cyc);
      if (bus.addr == ADDR_STATUS) begin
        bus.read_data <= (stat_reads - stat_base >= miss_target) ? 32'h1 : 32'h0;
        stat_reads <= stat_reads + 1;
      end else if (bus.addr >= ADDR_OUTPUT_BASE) begin
        bus.read_data <= 32'h1000_0000 | {24'd0, bus.addr - ADDR_OUTPUT_BASE};
      end else begin
        bus.read_data <= 32'hdead_beef;
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int wb, rb;

  task automatic run_job(input int miss, output int lat);
    int acc;
    wb = wr_addr.size();
    rb = rd_addr.size();
    stat_base = stat_reads;
    miss_target = miss;
    @(negedge clk);
    chk("job_ready_idle", 512'(job_ready), 512'(1));
    job_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    job_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = cyc - acc;
        break;
      end
    end
    if (lat < 0) chk("res_valid_wait", 512'(0), 512'(1));
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("ack_res_valid", 512'(res_valid), 512'(0));
    chk("ack_job_ready", 512'(job_ready), 512'(1));
  endtask

  logic [511:0] exp_res;
  logic [31:0]  kw;
  int           lat, n;

  initial begin
    job_key    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    job_nonce  = 96'h00000009_0000004a_00000000;
    job_rounds = 5'd20;
    job_keylen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      job_data[511-32*i -: 32] = 32'hd000_0000 + 32'(i);
      exp_res[511-32*i -: 32]  = 32'h1000_0000 + 32'(i);
    end

    repeat (3) @(negedge clk);
    chk("rst_cs", 512'(bus.cs), 512'(0));
    chk("rst_res_valid", 512'(res_valid), 512'(0));
    chk("rst_res_error", 512'(res_error), 512'(0));
    chk("rst_res_data", res_data, 512'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // write ordering, readback, latency
    run_job(0, lat);
    chk("lat_nominal", 512'(lat), 512'(69));
    chk("wr_count", 512'(wr_addr.size() - wb), 512'(31));
    for (int i = 0; i < 8; i++) begin
      kw = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      chk("wr_key_addr", 512'(wr_addr[wb+i]), 512'(8'h30 + 8'(i)));
      chk("wr_key_data", 512'(wr_data[wb+i]), 512'(kw));
    end
    chk("wr_key0", 512'(wr_data[wb]), 512'(32'h00010203));
    chk("wr_key7", 512'(wr_data[wb+7]), 512'(32'h1c1d1e1f));
    chk("wr_n0", 512'({wr_addr[wb+8], wr_data[wb+8]}), 512'({8'h38, 32'h9}));
    chk("wr_n1", 512'({wr_addr[wb+9], wr_data[wb+9]}), 512'({8'h39, 32'h4a}));
    chk("wr_n2", 512'({wr_addr[wb+10], wr_data[wb+10]}), 512'({8'h3a, 32'h0}));
    chk("wr_rounds", 512'({wr_addr[wb+11], wr_data[wb+11]}), 512'({8'h0d, 32'h14}));
    chk("wr_keylen", 512'({wr_addr[wb+12], wr_data[wb+12]}), 512'({8'h0c, 32'h1}));
    for (int i = 0; i < 16; i++)
      chk("wr_data", 512'({wr_addr[wb+13+i], wr_data[wb+13+i]}),
          512'({8'h50 + 8'(i), 32'hd000_0000 + 32'(i)}));
    chk("wr_b2b", 512'(wr_cyc[wb+28] - wr_cyc[wb]), 512'(28));
    chk("wr_ctrl_set", 512'({wr_addr[wb+29], wr_data[wb+29]}), 512'({8'h0a, 32'h1}));
    chk("wr_ctrl_clr", 512'({wr_addr[wb+30], wr_data[wb+30]}), 512'({8'h0a, 32'h0}));
    chk("init_hold", 512'(wr_cyc[wb+30] - wr_cyc[wb+29]), 512'(3));
    chk("rd_count", 512'(rd_addr.size() - rb), 512'(17));
    chk("rd_status", 512'(rd_addr[rb]), 512'(8'h0b));
    for (int i = 0; i < 16; i++)
      chk("rd_out_addr", 512'(rd_addr[rb+1+i]), 512'(8'h70 + 8'(i)));
    chk("res_hi", 512'(res_data[511:480]), 512'(32'h10000000));
    chk("res_lo", 512'(res_data[31:0]), 512'(32'h1000000f));
    chk("res_full", res_data, exp_res);
    chk("res_error0", 512'(res_error), 512'(0));
    ack();

    // five poll misses
    run_job(5, lat);
    chk("lat_poll", 512'(lat), 512'(79));
    chk("poll_rd_count", 512'(rd_addr.size() - rb), 512'(22));
    for (int i = 0; i < 6; i++) chk("poll_addr", 512'(rd_addr[rb+i]), 512'(8'h0b));
    for (int i = 0; i < 5; i++) chk("poll_gap", 512'(rd_cyc[rb+i+1] - rd_cyc[rb+i]), 512'(2));
    chk("poll_out_first", 512'(rd_addr[rb+6]), 512'(8'h70));
    chk("poll_res", res_data, exp_res);
    chk("poll_err", 512'(res_error), 512'(0));
    ack();

    // stuck status
    run_job(1000, lat);
    chk("to_rd_count", 512'(rd_addr.size() - rb), 512'(8));
    n = 0;
    for (int i = rb; i < rd_addr.size(); i++) if (rd_addr[i] != 8'h0b) n++;
    chk("to_no_out_reads", 512'(n), 512'(0));
    chk("to_err", 512'(res_error), 512'(1));
    chk("to_data", res_data, 512'(0));
    ack();

    // backpressure, then reset mid WR_DATA
    run_job(0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data", res_data, exp_res);
      chk("bp_job_ready", 512'(job_ready), 512'(0));
      chk("bp_res_valid", 512'(res_valid), 512'(1));
    end
    ack();
    wb = wr_addr.size();
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    n = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_addr.size() - wb >= 16) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("rst_mid_wait", 512'(0), 512'(1));
    chk("rst_mid_in_data", 512'(bus.addr >= 8'h50 && bus.addr <= 8'h5f), 512'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", 512'(bus.cs), 512'(0));
    chk("rst_mid_res_valid", 512'(res_valid), 512'(0));
    n = wr_addr.size() + rd_addr.size();
    repeat (3) @(negedge clk);
    chk("rst_mid_quiet", 512'(wr_addr.size() + rd_addr.size()), 512'(n));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_job_ready", 512'(job_ready), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
